phy_rx_sync_ctrl: RTL
=====================

PHY_RX_SYNC_CTRL -- requirements
Module: phy_rx_sync_ctrl

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 4, meaning consecutive 8'hBC bytes required to lock; legal range 2..15.
REQ-002 The block SHALL have parameter LOSS_CNT, default 3, meaning consecutive bad bytes that drop lock; legal range 1..15.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on posedge clk_f.
REQ-004 The block SHALL have port clk_f, input, 1, byte-rate clock.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port enable, input, 1, sync engine enable.
REQ-007 The block SHALL have port data_in, input, 8, parallel byte from the deserializer.
REQ-008 The block SHALL have port valid_in, input, 1, data_in carries payload.
REQ-009 The block SHALL have port data_out, output, 8, registered payload byte.
REQ-010 The block SHALL have port valid_out, output, 1, data_out is payload.
REQ-011 The block SHALL have port active, output, 1, link locked (state LOCKED or ALERT).
REQ-012 The block SHALL have port sync_state, output, 2, current FSM state encoding.
REQ-013 The block SHALL have port bc_seen, output, 1, registered pulse marking the cycle after data_in == 8'hBC.

Function
REQ-014 The block SHALL classify each byte: good = valid_in==1 or data_in==8'hBC; bad = otherwise.
REQ-015 The FSM SHALL use four states: HUNT=2'd0, CHECK=2'd1, LOCKED=2'd2, ALERT=2'd3; sync_state SHALL equal the state register.
REQ-016 HUNT: data_in==8'hBC -> CHECK with bc_cnt=1; any other byte -> stay in HUNT.
REQ-017 CHECK: 8'hBC -> bc_cnt+1, and -> LOCKED when bc_cnt+1 == LOCK_CNT; any non-BC byte -> HUNT with bc_cnt=0.
REQ-018 LOCKED: good byte -> stay in LOCKED; bad byte -> ALERT with bad_cnt=1, or directly -> HUNT if LOSS_CNT==1.
REQ-019 ALERT: good byte -> LOCKED with bad_cnt=0; bad byte -> bad_cnt+1, and -> HUNT when bad_cnt+1 == LOSS_CNT.
REQ-020 enable==0 SHALL force -> HUNT on the next edge and clear bc_cnt and bad_cnt; this overrides every transition except reset.
REQ-021 bc_cnt and bad_cnt SHALL be 4 bits wide and SHALL NOT wrap; each SHALL be cleared on every entry to HUNT.
REQ-022 active SHALL be decoded combinationally from the state register: 1 in LOCKED or ALERT, else 0.
REQ-023 valid_out SHALL be registered with 1-cycle latency: valid_out <= active && enable && valid_in && data_in != 8'hBC, evaluated with the pre-edge state.
REQ-024 data_out SHALL load data_in on the edges where valid_out is loaded with 1, and SHALL otherwise hold its value.
REQ-025 On the edge that leaves ALERT or LOCKED for HUNT, any byte that is still valid SHALL be forwarded, because REQ-023 uses the pre-edge state.

Reset
REQ-026 While reset==1 at an edge, the block SHALL set state=HUNT, bc_cnt=0, bad_cnt=0, data_out=8'h00, valid_out=0, bc_seen=0, so that active=0.
REQ-027 Reset SHALL take priority over enable and over all data inputs, including a reset asserted mid-lock.

Configuration
REQ-028 Macro RX_ERRCNT_EN, when defined, SHALL add output port err_cnt, 8 bits: a count of bad bytes received while active==1, saturating at 8'hFF, cleared only by reset.
REQ-029 Without RX_ERRCNT_EN, port err_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Bench: reset, then enable=1, then 4x 8'hBC -> sync_state steps 0,1,1,1,2; active=1 after the 4th BC edge; bc_seen pulses 4 times.
REQ-031 Bench: 2x BC, then 8'h55 with valid_in=0 -> return to HUNT; bc_cnt=0; active stays 0.
REQ-032 Bench: locked, then data 8'hA5/8'h3C with valid_in=1 -> data_out=8'hA5 then 8'h3C, each one cycle later, with valid_out=1; BC bytes produce valid_out=0.
REQ-033 Bench: locked, then 2 bad bytes, then 1 good byte -> states 2,3,3,2; then 3 bad bytes -> 3,3,0 and active drops on the 3rd edge.
REQ-034 Bench: locked, then enable=0 for one cycle -> HUNT next edge; valid_out=0; re-lock requires 4 new BCs.
REQ-035 Bench (RX_ERRCNT_EN defined): 300 bad bytes while kept locked via alternating good bytes -> err_cnt=8'hFF; reset asserted mid-lock -> all REQ-026 values and err_cnt=0 at the next edge.

Source files
------------

// File: rtl/phy_rx_sync_ctrl.sv
// Receive-side comma (8'hBC) sync FSM with registered payload forwarding.
// Optional: define RX_ERRCNT_EN to add the saturating err_cnt output.
module phy_rx_sync_ctrl #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3
) (
  input  logic       clk_f,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic [1:0] sync_state,
  output logic       bc_seen
`ifdef RX_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2,
    ALERT  = 2'd3
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_bc_cnt, w_bc_cnt_nxt;
  logic [3:0] r_bad_cnt, w_bad_cnt_nxt;
  logic [7:0] r_data_out;
  logic       r_valid_out;
  logic       r_bc_seen;

  logic       w_is_bc;
  logic       w_good;
  logic [4:0] w_bc_sum;
  logic [4:0] w_bad_sum;
  logic       w_fwd;

  assign w_is_bc   = (data_in == 8'hBC);
  assign w_good    = valid_in || w_is_bc;
  assign w_bc_sum  = {1'b0, r_bc_cnt} + 5'd1;
  assign w_bad_sum = {1'b0, r_bad_cnt} + 5'd1;
  assign active    = (r_state == LOCKED) || (r_state == ALERT);
  assign w_fwd     = active && enable && valid_in && !w_is_bc;

  always_comb begin
    w_state_nxt   = r_state;
    w_bc_cnt_nxt  = r_bc_cnt;
    w_bad_cnt_nxt = r_bad_cnt;
    if (!enable) begin
      w_state_nxt   = HUNT;
      w_bc_cnt_nxt  = '0;
      w_bad_cnt_nxt = '0;
    end else begin
      case (r_state)
        HUNT: begin
          w_bc_cnt_nxt  = '0;
          w_bad_cnt_nxt = '0;
          if (w_is_bc) begin
            w_state_nxt  = CHECK;
            w_bc_cnt_nxt = 4'd1;
          end
        end
        CHECK: begin
          if (w_is_bc) begin
            w_bc_cnt_nxt = (r_bc_cnt == 4'hF) ? 4'hF : w_bc_sum[3:0];
            if (w_bc_sum == 5'(LOCK_CNT)) w_state_nxt = LOCKED;
          end else begin
            w_state_nxt   = HUNT;
            w_bc_cnt_nxt  = '0;
            w_bad_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          if (!w_good) begin
            if (LOSS_CNT == 1) begin
              w_state_nxt   = HUNT;
              w_bc_cnt_nxt  = '0;
              w_bad_cnt_nxt = '0;
            end else begin
              w_state_nxt   = ALERT;
              w_bad_cnt_nxt = 4'd1;
            end
          end
        end
        ALERT: begin
          if (w_good) begin
            w_state_nxt   = LOCKED;
            w_bad_cnt_nxt = '0;
          end else if (w_bad_sum == 5'(LOSS_CNT)) begin
            w_state_nxt   = HUNT;
            w_bc_cnt_nxt  = '0;
            w_bad_cnt_nxt = '0;
          end else begin
            w_bad_cnt_nxt = (r_bad_cnt == 4'hF) ? 4'hF : w_bad_sum[3:0];
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      r_state     <= HUNT;
      r_bc_cnt    <= '0;
      r_bad_cnt   <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
      r_bc_seen   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bc_cnt    <= w_bc_cnt_nxt;
      r_bad_cnt   <= w_bad_cnt_nxt;
      r_valid_out <= w_fwd;
      r_bc_seen   <= w_is_bc;
      if (w_fwd) r_data_out <= data_in;
    end
  end

  assign data_out   = r_data_out;
  assign valid_out  = r_valid_out;
  assign sync_state = r_state;
  assign bc_seen    = r_bc_seen;

`ifdef RX_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk_f) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (active && !w_good && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule
